stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit stream multiplexer with round-robin arbitration and a registered output stage using valid/ready handshake.
- Successor to the fixed 8-input combinational select mux. Channel choice is made internally by fair arbitration rather than by an external select.
- Sits between multiple datapath producers (register file, ALU, memory/IO units) and a single shared consumer.

---
 rtl/stream_mux_pkg.sv | 23 ++
 rtl/stream_mux_rr_arbiter.sv | 104 ++++++++++
 rtl/stream_mux_rr.sv | 113 +++++++++++
 tb/tb_stream_mux_rr.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Packet locking is enabled by defining STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CHANNELS = 8;

   localparam logic OUT_VALID_RST    = 1'b0;
   localparam logic OUT_LAST_RST     = 1'b0;
   localparam logic OUT_DATA_RST_BIT = 1'b0;
   localparam int   OUT_CHAN_RST     = 0;
   localparam int   PTR_RST          = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and, with STREAM_MUX_PKT_LOCK_EN,
// the packet lock that pins the grant to one channel until its last beat.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS-1:0]        req,
   input  logic                       advance,
   input  logic [clog2(CHANNELS)-1:0] adv_idx,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic                       adv_last,
`endif
   output logic [CHANNELS-1:0]        grant,
   output logic [clog2(CHANNELS)-1:0] grant_idx,
   output logic                       grant_valid
);

   localparam int SEL_W = clog2(CHANNELS);

   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [CHANNELS-1:0] req_s;
   logic [SEL_W-1:0]    cand_s;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic                lock_q, lock_d;
   logic [SEL_W-1:0]    lock_chan_q, lock_chan_d;
`endif

   // Restrict requests to the locked channel while a packet is in flight
   always_comb begin
      req_s = req;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (lock_q) begin
         req_s = req & (CHANNELS'(1'b1) << lock_chan_q);
      end else begin
         req_s = req;
      end
`endif
   end

   // First requester scanning upward from the pointer, wrapping modulo CHANNELS
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = {SEL_W{1'b0}};
      cand_s      = {SEL_W{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         cand_s = ptr_q + SEL_W'(i);
         if (!grant_valid && req_s[cand_s]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_s;
         end else begin
            grant_idx = grant_idx;
         end
      end
      grant            = {CHANNELS{1'b0}};
      grant[grant_idx] = grant_valid;
   end

   // Pointer and lock next state on an accepted beat
   always_comb begin
      ptr_d = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_chan_d = lock_chan_q;
      if (advance) begin
         if (adv_last) begin
            lock_d = 1'b0;
            ptr_d  = adv_idx + SEL_W'(1'b1);
         end else begin
            lock_d      = 1'b1;
            lock_chan_d = adv_idx;
         end
      end else begin
         lock_d = lock_q;
      end
`else
      if (advance) begin
         ptr_d = adv_idx + SEL_W'(1'b1);
      end else begin
         ptr_d = ptr_q;
      end
`endif
   end

   // Arbitration state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= SEL_W'(PTR_RST);
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= 1'b0;
         lock_chan_q <= {SEL_W{1'b0}};
`endif
      end else begin
         ptr_q <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_chan_q <= lock_chan_d;
`endif
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with round-robin arbitration and a registered
// valid/ready output stage. STREAM_MUX_PKT_LOCK_EN adds in_last/out_last packet locking.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS*WIDTH-1:0]  in_data,
   input  logic [CHANNELS-1:0]        in_valid,
   output logic [CHANNELS-1:0]        in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [CHANNELS-1:0]        in_last,
   output logic                       out_last,
`endif
   output logic [WIDTH-1:0]           out_data,
   output logic [clog2(CHANNELS)-1:0] out_chan,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int SEL_W = clog2(CHANNELS);

   logic [CHANNELS-1:0] grant_s;
   logic [SEL_W-1:0]    grant_idx_s;
   logic                grant_valid_s;
   logic                space_s;
   logic                accept_s;

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SEL_W-1:0]    out_chan_q, out_chan_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic                out_last_q, out_last_d;
`endif

   rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (in_valid),
      .advance     (accept_s),
      .adv_idx     (grant_idx_s),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .adv_last    (in_last[grant_idx_s]),
`endif
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   assign space_s  = !out_valid_q || out_ready;
   assign accept_s = |(in_valid & in_ready);

   // Offer ready only to the granted channel, and only when the register can take a beat
   always_comb begin
      if (grant_valid_s && space_s && !reset) begin
         in_ready = grant_s;
      end else begin
         in_ready = {CHANNELS{1'b0}};
      end
   end

   // Output register next state: load on accept, drop valid on consume, else hold
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last_d  = out_last_q;
`endif
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
         out_chan_d  = grant_idx_s;
`ifdef STREAM_MUX_PKT_LOCK_EN
         out_last_d  = in_last[grant_idx_s];
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register; reset discards any held beat
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= OUT_VALID_RST;
         out_data_q  <= {WIDTH{OUT_DATA_RST_BIT}};
         out_chan_q  <= SEL_W'(OUT_CHAN_RST);
`ifdef STREAM_MUX_PKT_LOCK_EN
         out_last_q  <= OUT_LAST_RST;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven bench for stream_mux_rr (8 x 16-bit); the packet-lock
// sequence runs only when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

   logic         clk;
   logic         reset;
   logic [127:0] in_data;
   logic [7:0]   in_valid;
   logic [7:0]   in_ready;
   logic [15:0]  out_data;
   logic [2:0]   out_chan;
   logic         out_valid;
   logic         out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [7:0]   in_last;
   logic         out_last;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [7:0]  valid;
      logic [15:0] base;
      logic        rdy;
      logic [7:0]  ir;
      logic        ov;
      logic [15:0] od;
      logic [2:0]  oc;
   } vec_t;

   vec_t vecs[$];

   stream_mux_rr #(.WIDTH(16), .CHANNELS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic set_data(input logic [15:0] base);
      for (int k = 0; k < 8; k++) begin
         in_data[k*16 +: 16] = base + 16'(k);
      end
   endtask

   task automatic add(input logic rst, input logic [7:0] valid, input logic [15:0] base,
                      input logic rdy, input logic [7:0] ir, input logic ov,
                      input logic [15:0] od, input logic [2:0] oc);
      vec_t v;
      v.rst = rst; v.valid = valid; v.base = base; v.rdy = rdy;
      v.ir = ir; v.ov = ov; v.od = od; v.oc = oc;
      vecs.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs reflect the state left by the prior rising edge
   task automatic apply(input int id, input vec_t v);
      @(negedge clk);
      reset     = v.rst;
      in_valid  = v.valid;
      out_ready = v.rdy;
      set_data(v.base);
      #1;
      check($sformatf("row%0d in_ready", id), 32'(in_ready), 32'(v.ir));
      check($sformatf("row%0d out_valid", id), 32'(out_valid), 32'(v.ov));
      check($sformatf("row%0d out_data", id), 32'(out_data), 32'(v.od));
      check($sformatf("row%0d out_chan", id), 32'(out_chan), 32'(v.oc));
   endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
   task automatic lstep(input int id, input logic [7:0] v, input logic [15:0] d1,
                        input logic [7:0] lst, input logic [7:0] ir, input logic ov,
                        input logic [15:0] od, input logic [2:0] oc, input logic ol);
      @(negedge clk);
      reset     = 1'b0;
      in_valid  = v;
      out_ready = 1'b1;
      set_data(16'h5000);
      in_data[16 +: 16] = d1;
      in_last = lst;
      #1;
      check($sformatf("lock%0d in_ready", id), 32'(in_ready), 32'(ir));
      check($sformatf("lock%0d out_valid", id), 32'(out_valid), 32'(ov));
      check($sformatf("lock%0d out_data", id), 32'(out_data), 32'(od));
      check($sformatf("lock%0d out_chan", id), 32'(out_chan), 32'(oc));
      check($sformatf("lock%0d out_last", id), 32'(out_last), 32'(ol));
   endtask
`endif

   initial begin
      reset     = 1'b1;
      in_valid  = 8'h00;
      out_ready = 1'b1;
      in_data   = 128'h0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last   = 8'hFF;
`endif
      repeat (2) @(posedge clk);

      // Reset holds ready low even with requests pending, then idle
      add(1'b1, 8'hFF, 16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, 3'd0);
      for (int k = 0; k < 10; k++) begin
         add(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, 3'd0);
      end
      // Single channel: ch2 = 0xBEEF
      add(1'b0, 8'h04, 16'hBEED, 1'b1, 8'h04, 1'b0, 16'h0000, 3'd0);
      add(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'hBEEF, 3'd2);
      add(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 16'hBEEF, 3'd2);
      add(1'b1, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 16'hBEEF, 3'd2);
      // All eight valid from ptr=0: one beat per cycle in channel order, then wrap
      for (int k = 0; k < 8; k++) begin
         add(1'b0, 8'hFF, 16'h1000, 1'b1, 8'(1 << k), (k > 0),
             (k > 0) ? 16'h1000 + 16'(k - 1) : 16'h0000, (k > 0) ? 3'(k - 1) : 3'd0);
      end
      add(1'b0, 8'hFF, 16'h1000, 1'b1, 8'h01, 1'b1, 16'h1007, 3'd7);
      add(1'b0, 8'hFF, 16'h1000, 1'b1, 8'h02, 1'b1, 16'h1000, 3'd0);
      // Backpressure for 5 cycles with ch3/ch5 pending (ptr=2)
      for (int k = 0; k < 5; k++) begin
         add(1'b0, 8'h28, 16'h2000, 1'b0, 8'h00, 1'b1, 16'h1001, 3'd1);
      end
      add(1'b0, 8'h28, 16'h2000, 1'b1, 8'h08, 1'b1, 16'h1001, 3'd1);
      add(1'b0, 8'h20, 16'h2000, 1'b1, 8'h20, 1'b1, 16'h2003, 3'd3);
      add(1'b0, 8'h00, 16'h2000, 1'b1, 8'h00, 1'b1, 16'h2005, 3'd5);
      add(1'b0, 8'h00, 16'h2000, 1'b1, 8'h00, 1'b0, 16'h2005, 3'd5);
      // Reset while a beat is stalled; afterwards lowest valid channel wins
      add(1'b0, 8'h10, 16'h3000, 1'b0, 8'h10, 1'b0, 16'h2005, 3'd5);
      add(1'b0, 8'h10, 16'h3000, 1'b0, 8'h00, 1'b1, 16'h3004, 3'd4);
      add(1'b1, 8'h12, 16'h3000, 1'b0, 8'h00, 1'b1, 16'h3004, 3'd4);
      add(1'b0, 8'h12, 16'h3000, 1'b0, 8'h02, 1'b0, 16'h0000, 3'd0);
      add(1'b0, 8'h00, 16'h3000, 1'b1, 8'h00, 1'b1, 16'h3001, 3'd1);
      add(1'b0, 8'h00, 16'h3000, 1'b1, 8'h00, 1'b0, 16'h3001, 3'd1);
      // ptr=2 with only ch0/ch1 requesting: scan wraps to ch0 first
      add(1'b0, 8'h03, 16'h4000, 1'b1, 8'h01, 1'b0, 16'h3001, 3'd1);
      add(1'b0, 8'h03, 16'h4000, 1'b1, 8'h02, 1'b1, 16'h4000, 3'd0);
      add(1'b0, 8'h00, 16'h4000, 1'b1, 8'h00, 1'b1, 16'h4001, 3'd1);
      add(1'b1, 8'h00, 16'h4000, 1'b1, 8'h00, 1'b0, 16'h4001, 3'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(i, vecs[i]);
      end

`ifdef STREAM_MUX_PKT_LOCK_EN
      // ch0 first moves ptr to 1; ch1 then sends a 3-beat packet while ch0 keeps requesting
      lstep(0, 8'h01, 16'h5101, 8'hFF, 8'h01, 1'b0, 16'h0000, 3'd0, 1'b0);
      lstep(1, 8'h03, 16'h5101, 8'hFD, 8'h02, 1'b1, 16'h5000, 3'd0, 1'b1);
      lstep(2, 8'h03, 16'h5102, 8'hFD, 8'h02, 1'b1, 16'h5101, 3'd1, 1'b0);
      lstep(3, 8'h03, 16'h5103, 8'hFF, 8'h02, 1'b1, 16'h5102, 3'd1, 1'b0);
      lstep(4, 8'h01, 16'h5103, 8'hFF, 8'h01, 1'b1, 16'h5103, 3'd1, 1'b1);
      lstep(5, 8'h00, 16'h5103, 8'hFF, 8'h00, 1'b1, 16'h5000, 3'd0, 1'b1);
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
